// File: rtl/exec_mc.sv
// Multi-cycle RV32I-style execute stage: ALU/branch/jump in one cycle, loads/stores via req/ready.
// Optional iterative multiplier enabled by defining EXEC_MC_MUL_EN.
module exec_mc #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SHW         = $clog2(XLEN),
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [6:0]      op_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_in_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] mem_data_in_i,
  input  logic            mem_ready_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_data_out_o,
  output logic [1:0]      mem_acc_width_o,
  output logic [XLEN-1:0] val_out_o,
  output logic [XLEN-1:0] pc_out_o,
  output logic            flush_pipeline_o,
  output logic            mem_err_o,
  output logic            ready_o
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] ToLast = CntW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StMem, StDone, StMul} state_e;

  state_e state_q, state_d;

  logic [2:0]      f3_q, f3_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      width_q, width_d;
  logic [XLEN-1:0] val_q, val_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            err_q, err_d;
  logic            rdy_q, rdy_d;

`ifdef EXEC_MC_MUL_EN
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW:0]    mcnt_q, mcnt_d;
  logic            is_mul;
  assign is_mul = (op_i == OpOp) && (funct7_i == 7'b0000001) && (funct3_i == 3'b000);
`endif

  // Datapath operates on live inputs: results are registered on the capture edge itself.
  logic            is_rtype;
  logic            alt;
  logic [XLEN-1:0] op2;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] eff_addr;
  logic            br_eq, br_lt, br_ltu, br_taken;
  logic [1:0]      acc_width;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_ext;
  logic            timeout_hit;

  always_comb begin
    is_rtype = (op_i == OpOp);
    alt      = funct7_i[5];
    op2      = is_rtype ? rs2_i : imm_i;
    shamt    = op2[SHW-1:0];
    pc_plus4 = pc_in_i + XLEN'(4);
    pc_imm   = pc_in_i + imm_i;
    eff_addr = rs1_i + imm_i;

    case (funct3_i)
      3'b000:  alu_res = (is_rtype && alt) ? (rs1_i - op2) : (rs1_i + op2);
      3'b001:  alu_res = rs1_i << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(op2))};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, (rs1_i < op2)};
      3'b100:  alu_res = rs1_i ^ op2;
      3'b101:  alu_res = alt ? $unsigned($signed(rs1_i) >>> shamt) : (rs1_i >> shamt);
      3'b110:  alu_res = rs1_i | op2;
      default: alu_res = rs1_i & op2;
    endcase

    br_eq  = (rs1_i == rs2_i);
    br_lt  = ($signed(rs1_i) < $signed(rs2_i));
    br_ltu = (rs1_i < rs2_i);
    case (funct3_i)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase

    acc_width = (funct3_i[1:0] == 2'b11) ? 2'b10 : funct3_i[1:0];
    case (acc_width)
      2'b00:   store_data = {{(XLEN-8){1'b0}}, rs2_i[7:0]};
      2'b01:   store_data = {{(XLEN-16){1'b0}}, rs2_i[15:0]};
      default: store_data = rs2_i;
    endcase

    case (f3_q)
      3'b000:  load_ext = {{(XLEN-8){mem_data_in_i[7]}}, mem_data_in_i[7:0]};
      3'b001:  load_ext = {{(XLEN-16){mem_data_in_i[15]}}, mem_data_in_i[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, mem_data_in_i[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, mem_data_in_i[15:0]};
      default: load_ext = mem_data_in_i;
    endcase

    timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == ToLast);
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    val_d   = val_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    err_d   = err_q;
    rdy_d   = rdy_q;
`ifdef EXEC_MC_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mcnt_d   = mcnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          f3_d    = funct3_i;
          err_d   = 1'b0;
          flush_d = 1'b0;
          if ((op_i == OpLoad) || (op_i == OpStore)) begin
            state_d = StMem;
            req_d   = 1'b1;
            we_d    = (op_i == OpStore);
            addr_d  = eff_addr;
            width_d = acc_width;
            wdata_d = store_data;
            cnt_d   = '0;
`ifdef EXEC_MC_MUL_EN
          end else if (is_mul) begin
            state_d  = StMul;
            mcand_d  = rs1_i;
            mplier_d = rs2_i;
            acc_d    = '0;
            mcnt_d   = '0;
`endif
          end else begin
            state_d = StDone;
            rdy_d   = 1'b1;
            val_d   = '0;
            pc_d    = pc_plus4;
            case (op_i)
              OpLui:        val_d = imm_i;
              OpAuipc:      val_d = pc_imm;
              OpJal: begin
                val_d   = pc_plus4;
                pc_d    = pc_imm;
                flush_d = 1'b1;
              end
              OpJalr: begin
                val_d   = pc_plus4;
                pc_d    = {eff_addr[XLEN-1:1], 1'b0};
                flush_d = 1'b1;
              end
              OpBranch: begin
                pc_d    = pc_imm;
                flush_d = br_taken;
              end
              OpOp, OpImm:  val_d = alu_res;
              default:      val_d = '0;
            endcase
          end
        end
      end

      StMem: begin
        // Abort takes priority over a completion arriving in the same cycle.
        if (!en_i) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end else if (mem_ready_i) begin
          state_d = StDone;
          req_d   = 1'b0;
          rdy_d   = 1'b1;
          val_d   = we_q ? '0 : load_ext;
        end else if (timeout_hit) begin
          state_d = StDone;
          req_d   = 1'b0;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
          val_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        if (!en_i) begin
          state_d = StIdle;
          rdy_d   = 1'b0;
          flush_d = 1'b0;
          err_d   = 1'b0;
        end
      end

      StMul: begin
`ifdef EXEC_MC_MUL_EN
        if (!en_i) begin
          state_d = StIdle;
        end else if (mcnt_q == (SHW+1)'(XLEN)) begin
          state_d = StDone;
          rdy_d   = 1'b1;
          val_d   = acc_q;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          mcnt_d   = mcnt_q + (SHW+1)'(1);
        end
`else
        state_d = StIdle;
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      f3_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= 2'b10;
      val_q   <= '0;
      pc_q    <= '0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef EXEC_MC_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mcnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      val_q   <= val_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
`ifdef EXEC_MC_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mcnt_q   <= mcnt_d;
`endif
    end
  end

  assign mem_req_o        = req_q;
  assign mem_we_o         = we_q;
  assign mem_addr_o       = addr_q;
  assign mem_data_out_o   = wdata_q;
  assign mem_acc_width_o  = width_q;
  assign val_out_o        = val_q;
  assign pc_out_o         = pc_q;
  assign flush_pipeline_o = flush_q;
  assign mem_err_o        = err_q;
  assign ready_o          = rdy_q;

endmodule

// File: doc/exec_mc.md
Name: exec_mc

Overview:
- Multi-cycle, width-parametrised RV32I-style execute stage: consumes one decoded instruction while `en` is held and produces a registered result, next PC and a flush request.
- Differs from the current exec stage:
  - explicit FSM with asynchronous reset;
  - byte/half/word loads and stores with sign/zero extension;
  - memory-wait timeout with error flag;
  - correct handling of all six branch conditions.
- Sits between decode/regfile-read and writeback; talks to the memory arbiter via req/ready.

Parameters:
- XLEN, 32, datapath width (must be ≥ 16 and a power of two)
- SHW, $clog2(XLEN), shift-amount bits taken from operand 2
- MEM_TIMEOUT, 255, cycles to wait for `mem_ready` before abort; 0 disables timeout

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  instruction valid; held high until `ready` seen
- op  in  7  opcode
- funct7  in  7  R-type funct7
- funct3  in  3  funct3
- pc_in  in  XLEN  instruction PC
- rs1  in  XLEN  operand 1
- rs2  in  XLEN  operand 2 / store data
- imm  in  XLEN  sign-extended immediate
- mem_data_in  in  XLEN  load data, LSB-aligned
- mem_ready  in  1  memory completion
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  XLEN  rs1+imm
- mem_data_out  out  XLEN  store data
- mem_acc_width  out  2  00 byte, 01 half, 10 word
- val_out  out  XLEN  writeback value
- pc_out  out  XLEN  redirect target
- flush_pipeline  out  1  redirect taken
- mem_err  out  1  memory timeout occurred
- ready  out  1  result valid

Behaviour:
- Reset (async, immediate): state=IDLE; every output 0 except mem_acc_width=10; timeout counter 0.
- States: IDLE, MEM, DONE, MUL (MUL only with MUL_EN).
- Operands (op, funct3, funct7, pc_in, rs1, rs2, imm) are captured in IDLE on the first cycle with en=1. Later input changes are ignored until the FSM returns to IDLE.
- IDLE, en=1, op is not LOAD/STORE:
  - ALU/branch/jump result is computed combinationally from the captured operands and registered into val_out, pc_out and flush_pipeline.
  - Next state DONE; ready=1 one cycle after capture.
- IDLE, en=1, op is LOAD or STORE:
  - mem_req=1 (registered, asserted the cycle after capture).
  - mem_addr, mem_we, mem_acc_width and mem_data_out are held stable throughout MEM.
  - Next state MEM.
- MEM:
  - On mem_ready=1: mem_req drops the next cycle, val_out is loaded, state goes to DONE.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with no mem_ready: mem_req drops, mem_err=1, val_out=0, state goes to DONE.
- DONE:
  - ready, val_out, pc_out, flush_pipeline and mem_err are held while en=1.
  - en=0 → IDLE; ready, flush_pipeline and mem_err clear on that edge.
- en dropping in any state other than DONE aborts the instruction: state=IDLE, mem_req=0 on the next edge. A mem_ready arriving in the same cycle is ignored.
- ALU:
  - ADD/SUB selected by funct7[5] (R-type only; I-type is always ADD).
  - SLL/SRL/SRA use operand2[SHW-1:0]; SRA selected by funct7[5] for both R and I types.
  - SLT is signed; SLTU is unsigned.
- Other ops:
  - LUI: val=imm.
  - AUIPC: val=pc+imm.
  - JAL: val=pc+4, pc_out=pc+imm, flush=1.
  - JALR: val=pc+4, pc_out=(rs1+imm)&~1, flush=1.
  - BRANCH: pc_out=pc+imm; flush set if BEQ/BNE/BLT/BGE/BLTU/BGEU holds; val_out=0.
  - Branch funct3 010/011 and unknown opcodes: val_out=0, flush=0, ready still asserted.
- Loads:
  - funct3 000 LB, 001 LH and 010 LW: mem_data_in is sign-extended from the access width.
  - funct3 100 LBU and 101 LHU: mem_data_in is zero-extended from the access width.
- Stores: mem_data_out = rs2 masked to access width, upper bits 0.
- Addressing: no alignment checks.
- Arithmetic: all modulo 2^XLEN.

Optional Feature:
- Macro: EXEC_MC_MUL_EN.
- Defined:
  - OP_INTEGER with funct7=0000001 and funct3=000 (MUL) enters state MUL.
  - MUL is an iterative shift-add, 1 bit/cycle, XLEN cycles; val_out = low XLEN bits of rs1*rs2; then DONE.
  - ready is asserted XLEN+1 cycles after capture.
- Not defined: funct7=0000001 decodes as a normal R-type op selected by funct3, with modifier 0.

Test Plan:
- ADD rs1=5, rs2=0xFFFFFFFD, funct7=0 → val_out=2, ready 1 cycle after en; SUB (funct7=0x20) 5−3 → 2.
- BGEU rs1=1, rs2=0xFFFFFFFF, pc=0x100, imm=0x20 → flush=0; BLTU same operands → flush=1, pc_out=0x120.
- LB with mem_data_in=0x00000080, mem_ready after 3 cycles → val_out=0xFFFFFF80; LBU → 0x80; mem_req high exactly until the edge after mem_ready.
- SH rs1=0x1000, imm=4, rs2=0xDEADBEEF → mem_addr=0x1004, mem_we=1, mem_acc_width=01, mem_data_out=0x0000BEEF.
- Load with mem_ready never asserted, MEM_TIMEOUT=4 → mem_req drops, mem_err=1, ready=1, val_out=0.
- rst pulsed mid-MEM → mem_req=0 and ready=0 immediately; with EXEC_MC_MUL_EN, 7*0xFFFFFFFF → 0xFFFFFFF9 after 33 cycles.
